// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg: shared mode/direction constants and home-state helper for the shift counters
package ring_counter_pkg;
  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  function automatic logic [63:0] home_state(input logic mode, input logic [63:0] seed);
    return (mode == MODE_JOHNSON) ? 64'd0 : seed;
  endfunction
endpackage

// File: rtl/ring_state_checker.sv
// ring_state_checker: flags whether a counter value is legal for ring or Johnson mode
module ring_state_checker
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] Cout,
  input  logic             mode,
  output logic             valid
);
  // Johnson states are a single run of ones against zeros, so adjacent bits differ at most once
  assign valid = (mode == MODE_JOHNSON) ? ($countones(Cout[WIDTH-1:1] ^ Cout[WIDTH-2:0]) <= 1)
                                        : ($countones(Cout) == 1);
endmodule

// File: rtl/multimode_ring_counter.sv
// multimode_ring_counter: ring/Johnson shift counter with preset, load, terminal count and auto-correction
module multimode_ring_counter
  import ring_counter_pkg::*;
#(
  parameter int          WIDTH        = 4,
  parameter int unsigned SEED         = 1,
  parameter bit          AUTO_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] Cout,
  output logic             tc,
  output logic             valid,
  output logic             corrected
);
  if (WIDTH < 2) begin : g_bad_width
    $error("multimode_ring_counter: WIDTH must be at least 2");
  end
  if (($countones(SEED) != 1) || ((SEED >> WIDTH) != 0)) begin : g_bad_seed
    $error("multimode_ring_counter: SEED must be one-hot within WIDTH");
  end
  logic [WIDTH-1:0] home, shifted, nxt;
  logic             nxt_tc, nxt_corr, fill;
  ring_state_checker #(.WIDTH(WIDTH)) u_checker (
    .Cout  (Cout),
    .mode  (mode),
    .valid (valid)
  );
  assign home    = WIDTH'(home_state(mode, 64'(SEED)));
  assign fill    = (dir == DIR_LEFT) ? Cout[WIDTH-1] : Cout[0];
  assign shifted = (dir == DIR_LEFT) ? {Cout[WIDTH-2:0], fill ^ mode}
                                     : {fill ^ mode, Cout[WIDTH-1:1]};
  always_comb begin
    nxt      = Cout;
    nxt_tc   = 1'b0;
    nxt_corr = 1'b0;
    if (preset) nxt = home;
    else if (load) nxt = load_value;
    else if (enable) begin
      if (AUTO_CORRECT && !valid) begin
        nxt      = home;
        nxt_corr = 1'b1;
      end else begin
        nxt    = shifted;
        nxt_tc = (shifted == home);
      end
    end
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      Cout      <= '0;
      tc        <= 1'b0;
      corrected <= 1'b0;
    end else begin
      Cout      <= nxt;
      tc        <= nxt_tc;
      corrected <= nxt_corr;
    end
  end
endmodule

// File: tb/tb_multimode_ring_counter.sv
// tb_multimode_ring_counter: directed and randomized checks of both auto-correct variants against a behavioural model
module tb_multimode_ring_counter;
  logic clk = 1'b0, clear = 1'b1, enable = 1'b0, preset = 1'b0, load = 1'b0, mode = 1'b0, dir = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] c_a, c_n;
  logic tc_a, tc_n, v_a, v_n, k_a, k_n;
  int errors = 0, checks = 0;
  bit run = 1'b0;
  logic [3:0] mc [2];
  logic mtc [2], mk [2];
  always #5 clk = ~clk;
  multimode_ring_counter #(.WIDTH(4), .SEED(1), .AUTO_CORRECT(1'b1)) dut (
    .clk(clk), .clear(clear), .enable(enable), .preset(preset), .load(load),
    .load_value(load_value), .mode(mode), .dir(dir),
    .Cout(c_a), .tc(tc_a), .valid(v_a), .corrected(k_a)
  );
  multimode_ring_counter #(.WIDTH(4), .SEED(1), .AUTO_CORRECT(1'b0)) dut_nc (
    .clk(clk), .clear(clear), .enable(enable), .preset(preset), .load(load),
    .load_value(load_value), .mode(mode), .dir(dir),
    .Cout(c_n), .tc(tc_n), .valid(v_n), .corrected(k_n)
  );
  function automatic bit legal(logic [3:0] c, logic m);
    int t = 0;
    if (!m) return $countones(c) == 1;
    for (int i = 0; i < 3; i++) if (c[i] != c[i+1]) t++;
    return t <= 1;
  endfunction
  function automatic logic [3:0] step_fn(logic [3:0] c, logic m, logic d);
    int v = int'(c);
    int f;
    if (!d) begin
      f = m ? ((v & 1) ^ 1) : (v & 1);
      v = (v >> 1) | (f << 3);
    end else begin
      f = m ? (((v >> 3) & 1) ^ 1) : ((v >> 3) & 1);
      v = ((v << 1) & 15) | f;
    end
    return 4'(v);
  endfunction
  function automatic logic [5:0] model_next(logic [3:0] c, bit ac);
    logic [3:0] home = mode ? 4'd0 : 4'd1;
    logic [3:0] s;
    if (preset) return {2'b00, home};
    if (load) return {2'b00, load_value};
    if (!enable) return {2'b00, c};
    if (ac && !legal(c, mode)) return {2'b01, home};
    s = step_fn(c, mode, dir);
    return {s == home, 1'b0, s};
  endfunction
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < 2; k++) begin
        mc[k]  <= 4'd0;
        mtc[k] <= 1'b0;
        mk[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) {mtc[k], mk[k], mc[k]} <= model_next(mc[k], k == 0);
    end
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (run) begin
      check("model_cout_ac", 32'(c_a), 32'(mc[0]));
      check("model_tc_ac", 32'(tc_a), 32'(mtc[0]));
      check("model_corr_ac", 32'(k_a), 32'(mk[0]));
      check("model_valid_ac", 32'(v_a), 32'(legal(mc[0], mode)));
      check("model_cout_nc", 32'(c_n), 32'(mc[1]));
      check("model_tc_nc", 32'(tc_n), 32'(mtc[1]));
      check("model_corr_nc", 32'(k_n), 32'(mk[1]));
      check("model_valid_nc", 32'(v_n), 32'(legal(mc[1], mode)));
    end
  end
  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_a(string n, logic [3:0] c, logic t, logic k);
    check({n, "_cout"}, 32'(c_a), 32'(c));
    check({n, "_tc"}, 32'(tc_a), 32'(t));
    check({n, "_corr"}, 32'(k_a), 32'(k));
  endtask
  task automatic chk_n(string n, logic [3:0] c, logic t, logic k);
    check({n, "_cout_nc"}, 32'(c_n), 32'(c));
    check({n, "_tc_nc"}, 32'(tc_n), 32'(t));
    check({n, "_corr_nc"}, 32'(k_n), 32'(k));
  endtask
  logic [3:0] jseq [8] = '{4'h8, 4'hc, 4'he, 4'hf, 4'h7, 4'h3, 4'h1, 4'h0};
  logic [3:0] lseq [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
  initial begin
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    run = 1'b1;
    #1;
    chk_a("reset", 4'h0, 1'b0, 1'b0);
    check("reset_valid_ring", 32'(v_a), 32'd0);
    enable = 1'b1;
    edge_wait(); chk_a("ring_fix", 4'h1, 1'b0, 1'b1);
    edge_wait(); chk_a("ring_s1", 4'h8, 1'b0, 1'b0);
    edge_wait(); chk_a("ring_s2", 4'h4, 1'b0, 1'b0);
    edge_wait(); chk_a("ring_s3", 4'h2, 1'b0, 1'b0);
    edge_wait(); chk_a("ring_wrap", 4'h1, 1'b1, 1'b0);
    enable = 1'b0;
    mode = 1'b1;
    preset = 1'b1;
    edge_wait(); chk_a("john_preset", 4'h0, 1'b0, 1'b0);
    preset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      edge_wait(); chk_a($sformatf("john_s%0d", i), jseq[i], i == 7, 1'b0);
    end
    enable = 1'b0;
    mode = 1'b0;
    #1 check("mode_switch_valid", 32'(v_a), 32'd0);
    load = 1'b1;
    load_value = 4'b1010;
    edge_wait(); chk_a("load", 4'ha, 1'b0, 1'b0); chk_n("load", 4'ha, 1'b0, 1'b0);
    check("load_valid", 32'(v_a), 32'd0);
    load = 1'b0;
    enable = 1'b1;
    edge_wait(); chk_a("load_fix", 4'h1, 1'b0, 1'b1); chk_n("nc_s1", 4'h5, 1'b0, 1'b0);
    check("nc_valid1", 32'(v_n), 32'd0);
    edge_wait(); chk_a("post_fix1", 4'h8, 1'b0, 1'b0); chk_n("nc_s2", 4'ha, 1'b0, 1'b0);
    check("nc_valid2", 32'(v_n), 32'd0);
    edge_wait(); chk_a("post_fix2", 4'h4, 1'b0, 1'b0); chk_n("nc_s3", 4'h5, 1'b0, 1'b0);
    enable = 1'b0;
    #1 clear = 1'b1;
    #1 chk_a("async_clear", 4'h0, 1'b0, 1'b0);
    clear = 1'b0;
    preset = 1'b1;
    edge_wait(); chk_a("preset", 4'h1, 1'b0, 1'b0);
    preset = 1'b0;
    dir = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_wait(); chk_a($sformatf("left_s%0d", i), lseq[i], i == 3, 1'b0);
    end
    enable = 1'b0;
    dir = 1'b0;
    load = 1'b1;
    load_value = 4'h8;
    edge_wait(); chk_a("load8", 4'h8, 1'b0, 1'b0);
    preset = 1'b1;
    load_value = 4'h4;
    enable = 1'b1;
    edge_wait(); chk_a("preset_wins", 4'h1, 1'b0, 1'b0);
    preset = 1'b0;
    load = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_wait(); chk_a($sformatf("hold%0d", i), 4'h1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      enable = $urandom_range(0, 3) != 0;
      preset = $urandom_range(0, 19) == 0;
      load = $urandom_range(0, 11) == 0;
      load_value = 4'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) begin
        #1 clear = 1'b1;
        #1 clear = 1'b0;
      end
    end
    edge_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
